// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative multiply/divide unit for the EX stage.
//   Owns the architectural HI/LO registers. mult/multu use shift-add,
//   div/divu use restoring division on operand magnitudes; a final FIX
//   cycle applies the recorded signs. mthi/mtlo write HI/LO directly.
// Ports:
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   start   launch request (honoured only while idle)
//   MDCode  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 11x nop
//   A, B    operands (A is also the mthi/mtlo source)
//   busy    multi-cycle operation in flight
//   done    one-cycle pulse: HI/LO hold the new result
//   HI, LO  architectural result registers
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       MDCode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] acc;     // mult: {partial hi, multiplier/low}; div: {rem, quot}
    logic [WIDTH-1:0]   opnd;    // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_lo;  // product sign (mult) or quotient sign (div)
    logic               neg_hi;  // remainder sign (div only)
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    // Conditional two's-complement negation.
    function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cneg2(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + (2*WIDTH)'(1)) : v;
    endfunction

    logic               op_go, mthi_go, mtlo_go;
    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_shift;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;

    assign op_go     = (state == IDLE) && start && !MDCode[2];
    assign mthi_go   = (state == IDLE) && start && (MDCode == 3'b100);
    assign mtlo_go   = (state == IDLE) && start && (MDCode == 3'b101);

    assign signed_op = ~MDCode[0];
    assign a_neg     = signed_op & A[WIDTH-1];
    assign b_neg     = signed_op & B[WIDTH-1];
    assign a_mag     = cneg(A, a_neg);
    assign b_mag     = cneg(B, b_neg);

    // Shift-add step: the carry out of the upper-half add is shifted back
    // in so the 2W accumulator never overflows (e.g. 2^(W-1) * 2^(W-1)).
    assign mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign mul_next  = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};

    // Restoring step: the shifted remainder can need W+1 bits when the
    // divisor exceeds 2^(W-1), so the trial keeps the bit shifted out of acc.
    assign div_shift = {acc[2*WIDTH-2:0], 1'b0};
    assign div_trial = {1'b0, acc[2*WIDTH-1], acc[2*WIDTH-2:WIDTH-1]} - {2'b00, opnd};
    assign div_next  = div_trial[WIDTH+1] ? div_shift
                                          : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_fix  = cneg2(acc, neg_lo);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (op_go) state_nxt = CALC;
            CALC:    if (count == CW'(WIDTH-1)) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == FIX);
            case (state)
                IDLE: begin
                    if (op_go) begin
                        count  <= '0;
                        is_div <= MDCode[1];
                        if (MDCode[1]) begin
                            acc    <= {{WIDTH{1'b0}}, a_mag};
                            opnd   <= b_mag;
                            // A zero divisor must leave the all-ones quotient un-negated.
                            neg_lo <= (a_neg ^ b_neg) & (B != '0);
                            neg_hi <= a_neg;
                        end else begin
                            acc    <= {{WIDTH{1'b0}}, b_mag};
                            opnd   <= a_mag;
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= 1'b0;
                        end
                    end else if (mthi_go) begin
                        hi_q <= A;
                    end else if (mtlo_go) begin
                        lo_q <= A;
                    end
                end
                CALC: begin
                    acc   <= is_div ? div_next : mul_next;
                    count <= count + CW'(1);
                end
                FIX: begin
                    if (is_div) begin
                        lo_q <= cneg(acc[WIDTH-1:0], neg_lo);
                        hi_q <= cneg(acc[2*WIDTH-1:WIDTH], neg_hi);
                    end else begin
                        lo_q <= prod_fix[WIDTH-1:0];
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_alu_muldiv.sv
module tb_alu_muldiv;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   MDCode = 3'b111;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done;
    logic [W-1:0] HI, LO;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .MDCode(MDCode),
        .A(A), .B(B), .busy(busy), .done(done), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 expected no pending op");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_hi", HI, e.hi);
                check("result_lo", LO, e.lo);
            end
        end
    end

    // Presents one request for a single edge; caller sits just after a posedge.
    // Operands are scrambled afterwards to show the in-flight op ignores them.
    task automatic launch(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        MDCode = code;
        A      = a;
        B      = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        MDCode = 3'b111;
        A      = ~a;
        B      = ~b;
    endtask

    task automatic expect_op(input logic [W-1:0] hi, input logic [W-1:0] lo);
        exp_t e;
        e.hi = hi;
        e.lo = lo;
        exp_q.push_back(e);
    endtask

    // Called right after launch returns; waits (bounded) for done and checks timing.
    task automatic wait_done(input string name);
        int n;
        int busy_n;
        n = 0;
        busy_n = busy ? 1 : 0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (busy) busy_n++;
            if (n > 60) break;
        end
        check({name, "_latency"}, n, W + 1);
        check({name, "_busy_cycles"}, busy_n, W + 1);
    endtask

    task automatic run_op(input string name, input logic [2:0] code,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] hi, input logic [W-1:0] lo);
        expect_op(hi, lo);
        launch(code, a, b);
        wait_done(name);
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_hi", HI, 0);
        check("reset_lo", LO, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Signed multiply 7 * -3 = -21; also verify HI/LO hold during busy.
        expect_op(32'hFFFF_FFFF, 32'hFFFF_FFEB);
        launch(3'b000, 32'd7, 32'hFFFF_FFFD);
        check("mult_busy_rise", {31'd0, busy}, 1);
        check("mult_hold_lo", LO, 0);
        wait_done("mult_7x-3");

        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_minmin", 3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_op("div_-7_2", 3'b010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // divu, then an immediately accepted back-to-back divu by zero.
        run_op("divu_7", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC);
        expect_op(32'h0000_1234, 32'hFFFF_FFFF);
        launch(3'b011, 32'h0000_1234, 32'd0);
        check("b2b_busy_rise", {31'd0, busy}, 1);
        wait_done("divu_by_zero");

        run_op("div_signed_by_zero", 3'b010, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF);
        run_op("div_overflow", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // mtlo while idle: immediate write, HI untouched, no handshake activity.
        launch(3'b101, 32'hCAFE_F00D, 32'd0);
        check("mtlo_lo", LO, 32'hCAFE_F00D);
        check("mtlo_hi", HI, 32'h0000_0000);
        check("mtlo_busy", {31'd0, busy}, 0);
        check("mtlo_done", {31'd0, done}, 0);
        launch(3'b100, 32'hAAAA_5555, 32'd0);
        check("mthi_hi", HI, 32'hAAAA_5555);
        check("mthi_lo", LO, 32'hCAFE_F00D);

        // mthi during busy must be dropped.
        expect_op(32'h0000_0000, 32'h0000_0006);
        launch(3'b001, 32'd2, 32'd3);
        repeat (4) @(posedge clk);
        #1;
        launch(3'b100, 32'hDEAD_BEEF, 32'd0);
        check("busy_mthi_ignored", HI, 32'hAAAA_5555);
        check("busy_still", {31'd0, busy}, 1);
        begin
            int n;
            n = 0;
            while (!done && n < 60) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("ignored_mthi_done_seen", {31'd0, done}, 1);
        end
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of CALC aborts the op.
        launch(3'b100, 32'h5A5A_5A5A, 32'd0);
        launch(3'b000, 32'h1234_5678, 32'd9);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check("abort_hi", HI, 0);
        check("abort_lo", LO, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("mult_3x5", 3'b000, 32'd3, 32'd5, 32'd0, 32'd15);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got time limit expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised multi-cycle multiply/divide unit that sits beside the single-cycle ALU in the EX stage of the MIPS datapath. It implements mult/multu/div/divu with an iterative shift-add / restoring-divide datapath, owns the architectural HI/LO registers, and serves mthi/mtlo. The pipeline launches operations with a start/busy/done handshake and stalls on busy before issuing mfhi/mflo.

Parameters:
WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; the product is 2*WIDTH bits.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous reset, active-low
start  input  1  launch request, sampled on the clk edge
MDCode  input  3  operation select: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 nop
A  input  WIDTH  operand A: multiplicand, dividend, or mthi/mtlo source
B  input  WIDTH  operand B: multiplier or divisor
busy  output  1  multi-cycle operation in flight
done  output  1  one-cycle pulse; HI/LO hold the new result this cycle
HI  output  WIDTH  HI register: product upper half or remainder
LO  output  WIDTH  LO register: product lower half or quotient

Behaviour:
- Reset (rst_n=0, async): state=IDLE, busy=0, done=0, HI=0, LO=0, iteration counter=0, internal operand registers=0. Reset asserted mid-operation aborts it and HI/LO read 0. No partial result is ever written.
- States: IDLE, CALC, FIX. busy=1 in CALC and FIX, 0 in IDLE.
- IDLE, start=1, MDCode in 000..011:
  - At edge E0, capture operands and move to CALC with count=0.
  - For signed ops, capture |A| and |B|, and record sign flags: product sign = A[W-1]^B[W-1]; quotient sign = A[W-1]^B[W-1]; remainder sign = A[W-1].
  - Unsigned ops capture raw values with sign flags 0.
- CALC: one iteration per clock for WIDTH clocks.
  - Multiply: if multiplier LSB=1, add multiplicand into the upper half of the 2W accumulator (with carry), then shift right.
  - Divide: restoring. Shift {rem,quot} left by 1, trial-subtract the divisor, and keep the result with quotient bit 1 if non-negative.
  - After the WIDTH-th iteration (edge EW), go to FIX.
- FIX: apply two's-complement negation per the sign flags.
  - Multiply: negate the full 2W product.
  - Divide: negate quotient and remainder independently.
  - At edge EW+1: write HI/LO, set done=1 for exactly one cycle, busy=0, state=IDLE.
- Latency: result visible, with done=1, W+1 clock edges after the start edge. busy=1 for exactly W+1 cycles.
- Divide by zero (either sign): LO = all ones, HI = original A (un-negated). The same cycle count applies; no exception is raised.
- Signed overflow, A = most-negative and B = -1: LO = most-negative, HI = 0. This falls out of the magnitude path naturally and must not be special-cased into anything else.
- Signed multiply of most-negative by most-negative yields 2^(2W-2) exactly. The 2W accumulator must not overflow.
- mthi/mtlo when state=IDLE and start=1:
  - HI (or LO) <= A at that edge.
  - No busy, no done, the other register is unchanged.
- While busy=1:
  - start is ignored for every MDCode, including mthi/mtlo. The operation is not queued.
  - Input changes on A/B/MDCode do not affect the in-flight op.
- HI/LO keep their old values during busy and change only at the FIX edge.
- start=1 in the done cycle (busy=0) is accepted: back-to-back ops, with done and the new busy overlapping by zero cycles.
- start=1 with MDCode 110/111 is a nop: no state change.

Test Plan:
- Reset then mult A=7, B=0xFFFFFFFD (-3) -> busy high for 33 cycles, done pulse on the 33rd edge after start; HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- multu A=B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then mult A=B=0x80000000 -> HI=0x40000000, LO=0x00000000.
- div A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with the same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- Boundary cases:
  - divu A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x00001234.
  - div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- mtlo A=0xCAFEF00D while idle -> LO=0xCAFEF00D next edge, HI unchanged, done stays 0.
- Ignore and overlap rules:
  - start mthi during busy -> ignored; HI holds its old value until done.
  - start in the done cycle -> accepted, and busy rises the next cycle.
- rst_n pulsed low mid-CALC (iteration 10) -> busy=0, done=0, HI=LO=0 immediately (asynchronous). A subsequent mult 3*5 -> LO=15, HI=0.
